// File: rtl/key_mux_reg.sv
// -----------------------------------------------------------------------------
// key_mux_reg
//
// Two independent datapath primitives sharing only clock and reset:
//
//   1. Enabled register (stage/buffer latch). On each rising clock edge it
//      loads RESET_VAL when reset is high, loads reg_din when reg_wen is high,
//      and otherwise holds. reg_dout is taken straight from the flop, so there
//      is no combinational path from reg_din.
//
//   2. Keyed multiplexer with default (lookup-table select). This is purely
//      combinational and ignores reset. mux_lut packs NR_KEY {key, data}
//      pairs, with pair 0 in the MSBs. mux_out is data_i for the matching
//      key_i, and mux_default when no key matches. If several keys match,
//      mux_out is the OR of every matching data_i.
//
// Ports
//   clock        in   1                          rising-edge clock
//   reset        in   1                          synchronous, active-high reset
//   reg_din      in   WIDTH                      register next value
//   reg_wen      in   1                          register load enable
//   reg_dout     out  WIDTH                      register current value
//   mux_key      in   KEY_LEN                    select key
//   mux_default  in   DATA_LEN                   output when no key matches
//   mux_lut      in   NR_KEY*(KEY_LEN+DATA_LEN)  {key0,data0,key1,data1,...}
//   mux_out      out  DATA_LEN                   selected data
// -----------------------------------------------------------------------------
module key_mux_reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   parameter int               NR_KEY    = 2,
   parameter int               KEY_LEN   = 1,
   parameter int               DATA_LEN  = 1
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [WIDTH-1:0]                     reg_din,
   input  logic                                 reg_wen,
   output logic [WIDTH-1:0]                     reg_dout,
   input  logic [KEY_LEN-1:0]                   mux_key,
   input  logic [DATA_LEN-1:0]                  mux_default,
   input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] mux_lut,
   output logic [DATA_LEN-1:0]                  mux_out
);

   localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

   // ---------------------------------------------------------------- register
   logic [WIDTH-1:0] reg_dout_r;

   // Stage latch: reset dominates the load enable; otherwise hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         reg_dout_r <= RESET_VAL;
      end else if (reg_wen) begin
         reg_dout_r <= reg_din;
      end else begin
         reg_dout_r <= reg_dout_r;
      end
   end

   assign reg_dout = reg_dout_r;

   // -------------------------------------------------------------- keyed mux
   logic [KEY_LEN-1:0]  key_s  [NR_KEY];
   logic [DATA_LEN-1:0] data_s [NR_KEY];
   logic                hit_any_s;
   logic [DATA_LEN-1:0] hit_data_s;
   logic [DATA_LEN-1:0] mux_out_s;

   // Pair 0 sits in the MSBs, so pair g starts (NR_KEY-1-g) pairs above bit 0.
   // Inside a pair, the key is the upper KEY_LEN bits.
   for (genvar g = 0; g < NR_KEY; g++) begin : g_unpack
      assign key_s[g]  = mux_lut[(NR_KEY-1-g)*PAIR_LEN + DATA_LEN +: KEY_LEN];
      assign data_s[g] = mux_lut[(NR_KEY-1-g)*PAIR_LEN +: DATA_LEN];
   end

   // Match every key at once. When keys are duplicated, the matching data
   // words are ORed together; the default is used only when nothing matches.
   always_comb begin
      hit_any_s  = 1'b0;
      hit_data_s = {DATA_LEN{1'b0}};
      for (int i = 0; i < NR_KEY; i++) begin
         if (mux_key == key_s[i]) begin
            hit_any_s  = 1'b1;
            hit_data_s = hit_data_s | data_s[i];
         end else begin
            hit_data_s = hit_data_s;
         end
      end
      if (hit_any_s) begin
         mux_out_s = hit_data_s;
      end else begin
         mux_out_s = mux_default;
      end
   end

   assign mux_out = mux_out_s;

endmodule

// File: tb/tb_key_mux_reg.sv
// -----------------------------------------------------------------------------
// tb_key_mux_reg
//
// Scoreboard bench for key_mux_reg, using three instances:
//   A: 32-bit register, RESET_VAL 0;    mux 2 pairs, 1-bit key, 1-bit data
//   B: 5-bit register,  RESET_VAL 1F;   mux 3 pairs, 32-bit key, 32-bit data
//   C: 32-bit register, RESET_VAL 0;    mux 4 pairs, 2-bit key, 8-bit data
//
// The driver updates inputs on the falling edge and queues the expected
// results. The register expectations come from a next-value model, and the
// mux expectations come from a table-search model. One monitor checks the mux
// outputs shortly after the falling edge, before any clock edge has occurred.
// A second monitor checks the register outputs shortly after the rising edge.
// -----------------------------------------------------------------------------
module tb_key_mux_reg;

   typedef logic [63:0] tab_t [4];

   typedef struct packed {
      logic [31:0] a;
      logic [4:0]  b;
      logic [31:0] c;
   } reg_exp_t;

   typedef struct packed {
      logic [0:0]  a;
      logic [31:0] b;
      logic [7:0]  c;
   } mux_exp_t;

   logic clock = 1'b0;
   logic reset;

   logic [31:0]  a_din, a_dout;  logic a_wen;
   logic [0:0]   a_key, a_def, a_out; logic [3:0]   a_lut;
   logic [4:0]   b_din, b_dout;  logic b_wen;
   logic [31:0]  b_key, b_def, b_out; logic [191:0] b_lut;
   logic [31:0]  c_din, c_dout;  logic c_wen;
   logic [1:0]   c_key; logic [7:0] c_def, c_out; logic [39:0] c_lut;

   tab_t a_k, a_d, b_k, b_d, c_k, c_d;
   logic [31:0] a_m;
   logic [4:0]  b_m;
   logic [31:0] c_m;

   reg_exp_t reg_q [$];
   mux_exp_t mux_q [$];
   int n_checks = 0;
   int n_fail   = 0;

   key_mux_reg #(.WIDTH(32), .RESET_VAL(32'h0), .NR_KEY(2), .KEY_LEN(1), .DATA_LEN(1)) u_a (
      .clock(clock), .reset(reset), .reg_din(a_din), .reg_wen(a_wen), .reg_dout(a_dout),
      .mux_key(a_key), .mux_default(a_def), .mux_lut(a_lut), .mux_out(a_out));

   key_mux_reg #(.WIDTH(5), .RESET_VAL(5'h1F), .NR_KEY(3), .KEY_LEN(32), .DATA_LEN(32)) u_b (
      .clock(clock), .reset(reset), .reg_din(b_din), .reg_wen(b_wen), .reg_dout(b_dout),
      .mux_key(b_key), .mux_default(b_def), .mux_lut(b_lut), .mux_out(b_out));

   key_mux_reg #(.WIDTH(32), .RESET_VAL(32'h0), .NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) u_c (
      .clock(clock), .reset(reset), .reg_din(c_din), .reg_wen(c_wen), .reg_dout(c_dout),
      .mux_key(c_key), .mux_default(c_def), .mux_lut(c_lut), .mux_out(c_out));

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // The result is the OR of every data word whose key matches, or the
   // default when the list of matches is empty.
   function automatic logic [63:0] model_mux(input int n, input tab_t k, input tab_t d,
                                              input logic [63:0] key, input logic [63:0] def);
      logic [63:0] hits [$];
      logic [63:0] r;
      for (int i = 0; i < n; i++) if (k[i] == key) hits.push_back(d[i]);
      if (hits.size() == 0) return def;
      r = 64'h0;
      foreach (hits[j]) r = r | hits[j];
      return r;
   endfunction

   task automatic build_luts();
      a_lut = {a_k[0][0:0], a_d[0][0:0], a_k[1][0:0], a_d[1][0:0]};
      b_lut = {b_k[0][31:0], b_d[0][31:0], b_k[1][31:0], b_d[1][31:0],
               b_k[2][31:0], b_d[2][31:0]};
      c_lut = {c_k[0][1:0], c_d[0][7:0], c_k[1][1:0], c_d[1][7:0],
               c_k[2][1:0], c_d[2][7:0], c_k[3][1:0], c_d[3][7:0]};
   endtask

   // Called right after the inputs change on a falling edge.
   task automatic push_expect();
      reg_exp_t r;
      mux_exp_t m;
      build_luts();
      a_m = reset ? 32'h0 : (a_wen ? a_din : a_m);
      b_m = reset ? 5'h1F : (b_wen ? b_din : b_m);
      c_m = reset ? 32'h0 : (c_wen ? c_din : c_m);
      r.a = a_m; r.b = b_m; r.c = c_m;
      reg_q.push_back(r);
      m.a = model_mux(2, a_k, a_d, {63'h0, a_key}, {63'h0, a_def});
      m.b = model_mux(3, b_k, b_d, {32'h0, b_key}, {32'h0, b_def});
      m.c = model_mux(4, c_k, c_d, {62'h0, c_key}, {56'h0, c_def});
      mux_q.push_back(m);
   endtask

   // Register monitor: compares each value just after the edge that loads it.
   always @(posedge clock) begin
      reg_exp_t e;
      #1;
      if (reg_q.size() > 0) begin
         e = reg_q.pop_front();
         check("reg_a", a_dout, e.a);
         check("reg_b", b_dout, e.b);
         check("reg_c", c_dout, e.c);
      end
   end

   // Mux monitor: compares shortly after the inputs change, with no clock edge in between.
   always @(negedge clock) begin
      mux_exp_t e;
      #1;
      if (mux_q.size() > 0) begin
         e = mux_q.pop_front();
         check("mux_a", a_out, e.a);
         check("mux_b", b_out, e.b);
         check("mux_c", c_out, e.c);
      end
   end

   initial begin
      reset = 1'b1;
      a_wen = 1'b0; b_wen = 1'b0; c_wen = 1'b0;
      a_din = 32'h0; b_din = 5'h0; c_din = 32'h0;
      a_key = 1'b0; a_def = 1'b0; b_key = 32'h0; b_def = 32'h0; c_key = 2'b00; c_def = 8'h0;
      a_k = '{64'h0, 64'h1, 64'h0, 64'h0};  a_d = '{64'h1, 64'h0, 64'h0, 64'h0};
      b_k = '{64'hFF, 64'hFFFF, 64'hFFFF_FFFF, 64'h0};
      b_d = '{64'hA, 64'hB, 64'hC, 64'h0};
      c_k = '{64'h0, 64'h1, 64'h2, 64'h3};
      c_d = '{64'h11, 64'h22, 64'h33, 64'h44};
      a_m = 32'h0; b_m = 5'h0; c_m = 32'h0;
      build_luts();

      // Reset wins over the load enable; select the second B key.
      @(negedge clock);
      reset = 1'b1; a_wen = 1'b1; a_din = 32'hDEAD_BEEF; b_wen = 1'b1; b_din = 5'h0A;
      c_wen = 1'b1; c_din = 32'h5555_AAAA; b_key = 32'hFFFF; c_key = 2'b00; a_key = 1'b0;
      push_expect();
      // Load MSB-only pattern; B loads 03; the third B key.
      @(negedge clock);
      reset = 1'b0; a_din = 32'h8000_0000; b_din = 5'h03; c_din = 32'h0000_0001;
      b_key = 32'hFFFF_FFFF; c_key = 2'b01; a_key = 1'b1;
      push_expect();
      // Hold for three edges with new din; B key 0 gives the default; C walks its keys.
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         a_wen = 1'b0; b_wen = 1'b0; c_wen = 1'b0;
         a_din = 32'h1234; b_din = 5'h11; c_din = 32'h1234;
         b_key = (i == 0) ? 32'h0 : 32'hFF;
         c_key = 2'(i + 2);
         push_expect();
      end
      // Reset in the middle of the run: B goes back to 1F.
      @(negedge clock);
      reset = 1'b1; b_wen = 1'b1; b_din = 5'h03;
      push_expect();
      // Duplicate keys in C: key 1 returns 0F | F0; then key 0 returns the default.
      @(negedge clock);
      reset = 1'b0; b_wen = 1'b0;
      c_k = '{64'h1, 64'h1, 64'h2, 64'h3};
      c_d = '{64'h0F, 64'hF0, 64'h33, 64'h44};
      c_def = 8'h55; c_key = 2'b01;
      push_expect();
      @(negedge clock);
      c_key = 2'b00;
      push_expect();

      // Randomized traffic, with the tables refreshed from time to time.
      for (int n = 0; n < 300; n++) begin
         @(negedge clock);
         reset = ($urandom_range(0, 19) == 0);
         a_wen = 1'($urandom_range(0, 1)); b_wen = 1'($urandom_range(0, 1));
         c_wen = 1'($urandom_range(0, 1));
         a_din = $urandom(); b_din = 5'($urandom()); c_din = $urandom();
         if ($urandom_range(0, 7) == 0) begin
            for (int i = 0; i < 4; i++) begin
               a_k[i] = 64'($urandom_range(0, 1)); a_d[i] = 64'($urandom_range(0, 1));
               b_k[i] = ($urandom_range(0, 3) == 0) ? 64'hFF : 64'($urandom());
               b_d[i] = 64'($urandom());
               c_k[i] = 64'($urandom_range(0, 3)); c_d[i] = 64'($urandom_range(0, 255));
            end
         end
         a_key = 1'($urandom_range(0, 1)); a_def = 1'($urandom_range(0, 1));
         b_key = ($urandom_range(0, 3) == 0) ? 32'($urandom()) :
                 b_k[$urandom_range(0, 2)][31:0];
         b_def = $urandom();
         c_key = 2'($urandom_range(0, 3)); c_def = 8'($urandom_range(0, 255));
         push_expect();
      end

      // Give the monitors a bounded number of cycles to empty both queues.
      for (int i = 0; i < 5 && (reg_q.size() != 0 || mux_q.size() != 0); i++) begin
         @(posedge clock);
         #3;
      end
      check("queues_drained", 64'(reg_q.size() + mux_q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
